// File: rtl/dtmr_err_pkg.sv
// Shared encodings and LFSR tap table for the Dynamic-TMR fault injector.
package dtmr_err_pkg;

    typedef enum logic [1:0] {
        ERR_OFF    = 2'b00,
        ERR_RANDOM = 2'b01,
        ERR_BURST  = 2'b10,
        ERR_STUCK  = 2'b11
    } err_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        HOLDOFF = 2'd2
    } err_state_e;

    localparam int LFSR_W_MIN = 4;
    localparam int LFSR_W_MAX = 16;

    // Maximal-length Fibonacci taps, bit index 0-based from the LSB.
    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] t;
        unique case (w)
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h000C;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/err_inj_mc_if.sv
// Control, command and status bundle of the fault injector.
interface err_inj_mc_if #(
    parameter int CMD_L   = 4,
    parameter int N_CH    = 2,
    parameter int PRESC_W = 4
);
    logic                    en;
    logic [1:0]              mode;
    logic [PRESC_W-1:0]      presc;
    logic [N_CH-1:0]         ch_mask;
    logic [3:0]              burst_len;
    logic                    in_valid;
    logic [N_CH*CMD_L-1:0]   cmd_raw;
    logic                    out_valid;
    logic [N_CH*CMD_L-1:0]   cmd_out;
    logic                    inj_active;
    logic [15:0]             inj_cnt;

    modport master (
        output en, mode, presc, ch_mask, burst_len, in_valid, cmd_raw,
        input  out_valid, cmd_out, inj_active, inj_cnt
    );

    modport slave (
        input  en, mode, presc, ch_mask, burst_len, in_valid, cmd_raw,
        output out_valid, cmd_out, inj_active, inj_cnt
    );
endinterface

// File: rtl/err_lfsr.sv
// Fibonacci shift-left LFSR with step enable; an all-zero seed is replaced by 1.
module err_lfsr
    import dtmr_err_pkg::*;
#(
    parameter int W    = 4,
    parameter int SEED = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_i,
    output logic [W-1:0] lfsr_o
);
    localparam logic [W-1:0] TAPS   = W'(lfsr_taps(W));
    localparam logic [W-1:0] SEED_W = W'(SEED);
    localparam logic [W-1:0] SEED_V = (SEED_W == '0) ? W'(1) : SEED_W;

    logic [W-1:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_V;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/err_inj_mc.sv
// Multi-lane LFSR-scheduled fault injector (random / burst / stuck-at).
// Define ERR_INJ_LOG_EN to build the saturating injected-beat counter.
module err_inj_mc
    import dtmr_err_pkg::*;
#(
    parameter int CMD_L     = 4,
    parameter int N_CH      = 2,
    parameter int LFSR_W    = 4,
    parameter int LFSR_SEED = 5,
    parameter int PRESC_W   = 4
) (
    input logic         clk,
    input logic         rst,
    err_inj_mc_if.slave bus
);
    err_mode_e              mode;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic                   step;
    logic [LFSR_W-1:0]      lfsr;
    logic                   trig, trig_hi;
    err_state_e             state_q, state_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [PRESC_W-1:0]     hcnt_q, hcnt_d;
    logic                   lat_hi_q, lat_hi_d;
    logic [2*N_CH-1:0]      lat_dl_q, lat_dl_d, dl_now;
    logic                   perturb, use_lat, stuck;
    logic [N_CH*CMD_L-1:0]  cmd_d, cmd_out_q;
    logic [N_CH-1:0]        lane_chg;
    logic                   inj_d, inj_q, out_valid_q;

    assign mode = err_mode_e'(bus.mode);

    assign step    = (presc_q == bus.presc);
    assign presc_d = step ? '0 : presc_q + 1'b1;

    err_lfsr #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step_i (step),
        .lfsr_o (lfsr)
    );

    assign trig    = (lfsr[1:0] == 2'b11) || (lfsr[1:0] == 2'b00);
    assign trig_hi = (lfsr[1:0] == 2'b11);

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        hcnt_d   = hcnt_q;
        lat_hi_d = lat_hi_q;
        lat_dl_d = lat_dl_q;
        if (!bus.en || mode != ERR_BURST) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && trig) begin
                        state_d  = BURST;
                        lat_hi_d = trig_hi;
                        lat_dl_d = dl_now;
                        bcnt_d   = (bus.burst_len == 4'd0) ? 4'd1 : bus.burst_len;
                    end
                end
                BURST: begin
                    if (bus.in_valid) begin
                        bcnt_d = bcnt_q - 4'd1;
                        if (bcnt_q <= 4'd1) begin
                            state_d = HOLDOFF;
                            hcnt_d  = bus.presc;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hcnt_q == '0) state_d = IDLE;
                    else              hcnt_d  = hcnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign perturb = bus.en && ((mode == ERR_RANDOM && trig) ||
                                (mode == ERR_BURST && state_q == BURST));
    assign use_lat = (mode == ERR_BURST);
    assign stuck   = bus.en && (mode == ERR_STUCK);

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        localparam int HI  = (2*c + 3) % LFSR_W;
        localparam int LO  = (2*c + 2) % LFSR_W;
        localparam bit ODD = (c % 2) == 1;

        logic [CMD_L-1:0] raw, dlt, mod;
        logic             sub;

        assign dl_now[2*c +: 2] = {lfsr[HI], lfsr[LO]};
        assign raw = bus.cmd_raw[c*CMD_L +: CMD_L];
        assign dlt = CMD_L'(use_lat ? lat_dl_q[2*c +: 2] : dl_now[2*c +: 2]);
        // An 11 trigger subtracts on even lanes and adds on odd lanes.
        assign sub = (use_lat ? lat_hi_q : trig_hi) ^ ODD;

        always_comb begin
            mod = raw;
            if (bus.ch_mask[c]) begin
                if (stuck)        mod = '1;
                else if (perturb) mod = sub ? raw - dlt : raw + dlt;
            end
        end

        assign cmd_d[c*CMD_L +: CMD_L] = mod;
        assign lane_chg[c] = (mod != raw);
    end

    assign inj_d = bus.in_valid && (|lane_chg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            state_q     <= IDLE;
            bcnt_q      <= '0;
            hcnt_q      <= '0;
            lat_hi_q    <= 1'b0;
            lat_dl_q    <= '0;
            out_valid_q <= 1'b0;
            cmd_out_q   <= '0;
            inj_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            hcnt_q      <= hcnt_d;
            lat_hi_q    <= lat_hi_d;
            lat_dl_q    <= lat_dl_d;
            out_valid_q <= bus.in_valid;
            inj_q       <= inj_d;
            if (bus.in_valid) cmd_out_q <= cmd_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.cmd_out    = cmd_out_q;
    assign bus.inj_active = inj_q;

`ifdef ERR_INJ_LOG_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inj_d && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.inj_cnt = cnt_q;
`else
    assign bus.inj_cnt = '0;
`endif
endmodule

// File: tb/tb_err_inj_mc.sv
// Bench for err_inj_mc: fixed vectors, burst/stuck/reset sequences, random vs model.
module tb_err_inj_mc;
    import dtmr_err_pkg::*;

    localparam int CMD_L = 4, N_CH = 2, LFSR_W = 4, SEED = 5, PRESC_W = 4;
`ifdef ERR_INJ_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    err_inj_mc_if #(.CMD_L(CMD_L), .N_CH(N_CH), .PRESC_W(PRESC_W)) bus ();

    err_inj_mc #(
        .CMD_L(CMD_L), .N_CH(N_CH), .LFSR_W(LFSR_W),
        .LFSR_SEED(SEED), .PRESC_W(PRESC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    int m_lfsr, m_pc, m_left, m_hold, m_lat_hi;
    int m_lat_d [N_CH];
    int e_cmd, e_valid, e_inj, e_cnt;

    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic [1:0] mask;
        logic       iv;
        logic [7:0] raw;
        logic [7:0] x_cmd;
        logic       x_v;
        logic       x_inj;
    } vec_t;

    vec_t vecs [13];
    int   lseq [15];
    logic [7:0] b_cmd [9];
    logic       b_inj [9];
    logic       g_iv [8];
    logic       g_inj [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lane_delta(input int l, input int c);
        return (((l >> ((2*c+3) % LFSR_W)) & 1) << 1) | ((l >> ((2*c+2) % LFSR_W)) & 1);
    endfunction

    // 11 trigger: odd lanes go up, even lanes go down; 00 trigger the reverse.
    function automatic int shift_lane(input int raw, input int d, input int hi, input int c);
        bit up;
        up = (hi != 0) ? (c % 2 == 1) : (c % 2 == 0);
        return up ? (raw + d) % 16 : (raw - d + 16) % 16;
    endfunction

    function automatic int lfsr_next(input int l);
        return ((l << 1) & 15) | (((l >> 3) ^ (l >> 2)) & 1);
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_pc = 0; m_left = 0; m_hold = 0; m_lat_hi = 0;
        for (int c = 0; c < N_CH; c++) m_lat_d[c] = 0;
        e_cmd = 0; e_valid = 0; e_inj = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        int l, raw, v, nxt, en, md, msk, iv, cr, pr, bl;
        bit trig, hi, chg;
        l = m_lfsr;
        trig = (l % 4 == 3) || (l % 4 == 0);
        hi = (l % 4 == 3);
        en = int'(bus.en); md = int'(bus.mode); msk = int'(bus.ch_mask);
        iv = int'(bus.in_valid); cr = int'(bus.cmd_raw);
        pr = int'(bus.presc); bl = int'(bus.burst_len);
        nxt = 0; chg = 0;
        for (int c = 0; c < N_CH; c++) begin
            raw = (cr >> (4*c)) & 15;
            v = raw;
            if (en != 0 && ((msk >> c) & 1) != 0) begin
                if (md == 3) v = 15;
                else if (md == 1 && trig) v = shift_lane(raw, lane_delta(l, c), int'(hi), c);
                else if (md == 2 && m_left > 0) v = shift_lane(raw, m_lat_d[c], m_lat_hi, c);
            end
            if (v != raw) chg = 1;
            nxt = nxt | (v << (4*c));
        end
        e_valid = iv;
        e_inj = (iv != 0 && chg) ? 1 : 0;
        if (iv != 0) e_cmd = nxt;
        if (LOG && e_inj != 0 && e_cnt < 65535) e_cnt++;
        if (en == 0 || md != 2) begin
            m_left = 0; m_hold = 0;
        end else if (m_left > 0) begin
            if (iv != 0) begin
                m_left--;
                if (m_left == 0) m_hold = pr + 1;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (iv != 0 && trig) begin
            m_left = (bl == 0) ? 1 : bl;
            m_lat_hi = int'(hi);
            for (int c = 0; c < N_CH; c++) m_lat_d[c] = lane_delta(l, c);
        end
        if (m_pc == pr) begin
            m_lfsr = lfsr_next(m_lfsr); m_pc = 0;
        end else begin
            m_pc = (m_pc + 1) % 16;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int p);
        rst = 1'b1;
        bus.presc = 4'(p);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cmd"}, 32'(bus.cmd_out), 32'(e_cmd));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(e_valid));
        check({tag, ".inj"}, 32'(bus.inj_active), 32'(e_inj));
        check({tag, ".cnt"}, 32'(bus.inj_cnt), 32'(e_cnt));
        check({tag, ".lfsr"}, 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".cmd"}, 32'(bus.cmd_out), 32'h0);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, ".inj"}, 32'(bus.inj_active), 32'h0);
        check({tag, ".cnt"}, 32'(bus.inj_cnt), 32'h0);
        check({tag, ".lfsr"}, 32'(dut.u_lfsr.lfsr_q), 32'h5);
    endtask

    initial begin
        int pick;
        lseq = '{5, 11, 7, 15, 14, 12, 8, 1, 2, 4, 9, 3, 6, 13, 10};
        vecs[0]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h33, 8'h33, 1'b1, 1'b0};
        vecs[1]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'hF0, 8'h2E, 1'b1, 1'b1};
        vecs[2]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h00, 8'h3F, 1'b1, 1'b1};
        vecs[3]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h33, 8'h60, 1'b1, 1'b1};
        vecs[4]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h33, 8'h33, 1'b1, 1'b0};
        vecs[5]  = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h0F, 8'h02, 1'b1, 1'b1};
        vecs[6]  = '{ERR_RANDOM, 1'b1, 2'b10, 1'b1, 8'h55, 8'h55, 1'b1, 1'b0};
        vecs[7]  = '{ERR_STUCK,  1'b1, 2'b01, 1'b1, 8'h12, 8'h1F, 1'b1, 1'b1};
        vecs[8]  = '{ERR_STUCK,  1'b1, 2'b10, 1'b1, 8'hF3, 8'hF3, 1'b1, 1'b0};
        vecs[9]  = '{ERR_RANDOM, 1'b0, 2'b11, 1'b1, 8'h77, 8'h77, 1'b1, 1'b0};
        vecs[10] = '{ERR_OFF,    1'b1, 2'b11, 1'b1, 8'hAB, 8'hAB, 1'b1, 1'b0};
        vecs[11] = '{ERR_RANDOM, 1'b1, 2'b11, 1'b1, 8'h00, 8'h30, 1'b1, 1'b1};
        vecs[12] = '{ERR_RANDOM, 1'b1, 2'b11, 1'b0, 8'h44, 8'h30, 1'b0, 1'b0};
        b_cmd = '{8'h33, 8'h33, 8'h61, 8'h61, 8'h61, 8'h33, 8'h33, 8'h35, 8'h35};
        b_inj = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        g_iv  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        g_inj = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.en = 1'b1; bus.mode = ERR_OFF; bus.presc = '0; bus.ch_mask = 2'b11;
        bus.burst_len = 4'd3; bus.in_valid = 1'b0; bus.cmd_raw = 8'h00;

        do_reset(0);
        check_zero("reset");

        for (int k = 1; k <= 15; k++) begin
            tick();
            check("lfsr_p0", 32'(dut.u_lfsr.lfsr_q), 32'(lseq[k % 15]));
        end

        do_reset(3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("lfsr_p3", 32'(dut.u_lfsr.lfsr_q), 32'(lseq[k / 4]));
        end

        do_reset(0);
        for (int i = 0; i < 13; i++) begin
            bus.mode = vecs[i].mode; bus.en = vecs[i].en; bus.ch_mask = vecs[i].mask;
            bus.in_valid = vecs[i].iv; bus.cmd_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d.cmd", i), 32'(bus.cmd_out), 32'(vecs[i].x_cmd));
            check($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].x_v));
            check($sformatf("vec%0d.inj", i), 32'(bus.inj_active), 32'(vecs[i].x_inj));
        end

        bus.en = 1'b1; bus.mode = ERR_BURST; bus.ch_mask = 2'b11;
        bus.burst_len = 4'd3; bus.in_valid = 1'b1; bus.cmd_raw = 8'h33;
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("burst%0d.cmd", i), 32'(bus.cmd_out), 32'(b_cmd[i]));
            check($sformatf("burst%0d.inj", i), 32'(bus.inj_active), 32'(b_inj[i]));
        end
        rst = 1'b1;
        #2;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        check("postreset.cmd", 32'(bus.cmd_out), 32'h33);
        check("postreset.inj", 32'(bus.inj_active), 32'h0);

        bus.burst_len = 4'd2;
        do_reset(0);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = g_iv[i];
            tick();
            check($sformatf("gap%0d.inj", i), 32'(bus.inj_active), 32'(g_inj[i]));
            check($sformatf("gap%0d.valid", i), 32'(bus.out_valid), 32'(g_iv[i]));
        end

        bus.mode = ERR_STUCK; bus.ch_mask = 2'b01; bus.in_valid = 1'b1; bus.cmd_raw = 8'h12;
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stuck.cmd", 32'(bus.cmd_out), 32'h1F);
        end
        check("stuck.cnt10", 32'(bus.inj_cnt), LOG ? 32'd10 : 32'd0);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stuck_off.cmd", 32'(bus.cmd_out), 32'h12);
            check("stuck_off.inj", 32'(bus.inj_active), 32'h0);
        end
        check("stuck_off.cnt", 32'(bus.inj_cnt), LOG ? 32'd10 : 32'd0);

        for (int seg = 0; seg < 4; seg++) begin
            bus.en = 1'b1; bus.mode = ERR_BURST; bus.ch_mask = 2'b11;
            bus.burst_len = 4'($urandom_range(0, 5));
            do_reset($urandom_range(0, 3));
            for (int t = 0; t < 250; t++) begin
                if ($urandom_range(0, 19) == 0) begin
                    pick = $urandom_range(0, 5);
                    bus.mode = (pick > 3) ? ERR_BURST : 2'(pick);
                end
                if ($urandom_range(0, 15) == 0) bus.ch_mask = 2'($urandom);
                if ($urandom_range(0, 31) == 0) bus.burst_len = 4'($urandom_range(0, 5));
                bus.en = ($urandom_range(0, 15) != 0);
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.cmd_raw = 8'($urandom);
                tick();
                check_model($sformatf("rnd%0d_%0d", seg, t));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
